// File: rtl/iq_pkg.sv
// Shared types and constants for the instruction fetch queue and its decode-side helpers.
// Fetch groups are FETCH_W slots of INST_W bits each; bit VALID_BIT of a slot marks it valid.
package iq_pkg;
   localparam int FETCH_W   = 4;
   localparam int INST_W    = 33;
   localparam int VALID_BIT = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   // Slots within a fetch group sit at consecutive 4-byte PCs.
   function automatic logic [31:0] iq_slot_pc(input logic [31:0] base, input logic [1:0] slot);
      return base + {28'd0, slot, 2'b00};
   endfunction
endpackage

// File: rtl/iq_lead_count.sv
// Leading-ones count of fetch slot valid bits; combinational, no backpressure.
// A group ends at its first invalid slot, so anything after a hole is not counted.
module iq_lead_count
   import iq_pkg::*;
(
   input  logic [FETCH_W-1:0] slot_vld,
   output logic [2:0]         n_enq
);

   logic run;

   always_comb begin
      n_enq = 3'd0;
      run   = 1'b1;
      for (int i = 0; i < FETCH_W; i++) begin
         run = run & slot_vld[i];
         if (run) begin
            n_enq = n_enq + 3'd1;
         end
      end
   end

endmodule

// File: rtl/inst_queue.sv
// Circular fetch queue between I-cache and decode; writes visible the cycle after the edge, reads combinational.
// Accepts a whole group only when 4 entries are free; `define IQ_PERF_EN adds stall/empty cycle counters.
module inst_queue
   import iq_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              enq_valid,
   input  logic [31:0]       enq_pc,
   input  logic [INST_W-1:0] enq_inst0,
   input  logic [INST_W-1:0] enq_inst1,
   input  logic [INST_W-1:0] enq_inst2,
   input  logic [INST_W-1:0] enq_inst3,
   output logic              enq_ready,
   output logic [INST_W-1:0] deq_inst0,
   output logic [INST_W-1:0] deq_inst1,
   output logic [INST_W-1:0] deq_inst2,
   output logic [INST_W-1:0] deq_inst3,
   output logic [31:0]       deq_pc0,
   output logic [31:0]       deq_pc1,
   output logic [31:0]       deq_pc2,
   output logic [31:0]       deq_pc3,
   input  logic [2:0]        deq_num,
   output logic [PTR_W:0]    count
`ifdef IQ_PERF_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       empty_cycles
`endif
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] GROUP_C = (PTR_W+1)'(FETCH_W);

   iq_entry_t          mem_q [DEPTH];
   iq_entry_t          mem_d [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [PTR_W:0]     cnt_q, cnt_d;

   logic [INST_W-1:0]  enq_slot [FETCH_W];
   logic [FETCH_W-1:0] enq_vld;
   logic [2:0]         n_enq;
   logic [2:0]         deq_clamp;
   logic [PTR_W:0]     n_deq;
   logic               acc;
   logic [PTR_W-1:0]   wr_idx;
   logic [PTR_W-1:0]   rd_idx;
   logic [INST_W-1:0]  deq_inst_a [FETCH_W];
   logic [31:0]        deq_pc_a [FETCH_W];

   assign enq_slot[0] = enq_inst0;
   assign enq_slot[1] = enq_inst1;
   assign enq_slot[2] = enq_inst2;
   assign enq_slot[3] = enq_inst3;

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         enq_vld[i] = enq_slot[i][VALID_BIT];
      end
   end

   iq_lead_count u_lead (
      .slot_vld (enq_vld),
      .n_enq    (n_enq)
   );

   // Room is judged on registered occupancy only; same-cycle dequeues do not count.
   assign enq_ready = (DEPTH_C - cnt_q) >= GROUP_C;
   assign acc       = enq_valid & enq_ready;
   assign deq_clamp = (deq_num > 3'd4) ? 3'd4 : deq_num;
   assign n_deq     = ((PTR_W+1)'(deq_clamp) < cnt_q) ? (PTR_W+1)'(deq_clamp) : cnt_q;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q + PTR_W'(n_deq);
      tail_d = tail_q;
      cnt_d  = cnt_q - n_deq;
      wr_idx = '0;
      if (acc && !flush) begin
         for (int i = 0; i < FETCH_W; i++) begin
            wr_idx = tail_q + PTR_W'(i);
            if (3'(i) < n_enq) begin
               mem_d[wr_idx] = '{pc: iq_slot_pc(enq_pc, 2'(i)), inst: enq_slot[i][31:0]};
            end
         end
         tail_d = tail_q + PTR_W'(n_enq);
         cnt_d  = cnt_q + (PTR_W+1)'(n_enq) - n_deq;
      end
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry contents are don't-care until written, so storage carries no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_idx = '0;
      for (int k = 0; k < FETCH_W; k++) begin
         rd_idx        = head_q + PTR_W'(k);
         deq_inst_a[k] = '0;
         deq_pc_a[k]   = '0;
         if ((PTR_W+1)'(k) < cnt_q) begin
            deq_inst_a[k] = {1'b1, mem_q[rd_idx].inst};
            deq_pc_a[k]   = mem_q[rd_idx].pc;
         end
      end
   end

   assign deq_inst0 = deq_inst_a[0];
   assign deq_inst1 = deq_inst_a[1];
   assign deq_inst2 = deq_inst_a[2];
   assign deq_inst3 = deq_inst_a[3];
   assign deq_pc0   = deq_pc_a[0];
   assign deq_pc1   = deq_pc_a[1];
   assign deq_pc2   = deq_pc_a[2];
   assign deq_pc3   = deq_pc_a[3];
   assign count     = cnt_q;

`ifdef IQ_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] empty_cycles_q, empty_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      empty_cycles_d = empty_cycles_q;
      if (enq_valid && !enq_ready && !flush && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if ((cnt_q == '0) && (empty_cycles_q != 32'hFFFF_FFFF)) begin
         empty_cycles_d = empty_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stall_cycles_q <= '0;
         empty_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         empty_cycles_q <= empty_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign empty_cycles = empty_cycles_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: stimulus pushes the expected post-edge state into a scoreboard,
// and a negedge monitor pops and compares it against count, enq_ready and all four deq slots.
module tb_inst_queue;
   import iq_pkg::*;

   logic              clk = 1'b0;
   logic              resetn;
   logic              flush;
   logic              enq_valid;
   logic [31:0]       enq_pc;
   logic [INST_W-1:0] enq_inst0, enq_inst1, enq_inst2, enq_inst3;
   logic              enq_ready;
   logic [INST_W-1:0] deq_inst0, deq_inst1, deq_inst2, deq_inst3;
   logic [31:0]       deq_pc0, deq_pc1, deq_pc2, deq_pc3;
   logic [2:0]        deq_num;
   logic [4:0]        count;
`ifdef IQ_PERF_EN
   logic [31:0]       stall_cycles;
   logic [31:0]       empty_cycles;
`endif

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(16)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_pc    (enq_pc),
      .enq_inst0 (enq_inst0),
      .enq_inst1 (enq_inst1),
      .enq_inst2 (enq_inst2),
      .enq_inst3 (enq_inst3),
      .enq_ready (enq_ready),
      .deq_inst0 (deq_inst0),
      .deq_inst1 (deq_inst1),
      .deq_inst2 (deq_inst2),
      .deq_inst3 (deq_inst3),
      .deq_pc0   (deq_pc0),
      .deq_pc1   (deq_pc1),
      .deq_pc2   (deq_pc2),
      .deq_pc3   (deq_pc3),
      .deq_num   (deq_num),
      .count     (count)
`ifdef IQ_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .empty_cycles (empty_cycles)
`endif
   );

   logic [INST_W-1:0] dq_i [4];
   logic [31:0]       dq_p [4];
   assign dq_i[0] = deq_inst0;
   assign dq_i[1] = deq_inst1;
   assign dq_i[2] = deq_inst2;
   assign dq_i[3] = deq_inst3;
   assign dq_p[0] = deq_pc0;
   assign dq_p[1] = deq_pc1;
   assign dq_p[2] = deq_pc2;
   assign dq_p[3] = deq_pc3;

   typedef struct {
      int              tag;
      string           name;
      int              cnt;
      bit              rdy;
      logic [3:0][31:0] pc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction word is a fixed scramble of its PC, so each stored word identifies its origin.
   function automatic logic [31:0] enc(input logic [31:0] pc);
      return pc ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s %s: got %h expected %h", nm, fld, act, expv);
      end
   endtask

   task automatic exp_state(input string nm, input int cnt, input bit rdy,
                            input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2, input logic [31:0] p3);
      exp_t e;
      e.tag  = cyc + 1;
      e.name = nm;
      e.cnt  = cnt;
      e.rdy  = rdy;
      e.pc[0] = p0;
      e.pc[1] = p1;
      e.pc[2] = p2;
      e.pc[3] = p3;
      sbq.push_back(e);
   endtask

   task automatic step(input bit fl, input bit ev, input logic [31:0] pc,
                       input logic [3:0] vm, input logic [2:0] dn);
      flush     = fl;
      enq_valid = ev;
      enq_pc    = pc;
      enq_inst0 = {vm[0], enc(pc)};
      enq_inst1 = {vm[1], enc(pc + 32'd4)};
      enq_inst2 = {vm[2], enc(pc + 32'd8)};
      enq_inst3 = {vm[3], enc(pc + 32'd12)};
      deq_num   = dn;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].tag <= cyc) begin
         mon_e = sbq.pop_front();
         chk(mon_e.name, "cycle", 64'(cyc), 64'(mon_e.tag));
         chk(mon_e.name, "count", 64'(count), 64'(mon_e.cnt));
         chk(mon_e.name, "enq_ready", 64'(enq_ready), 64'(mon_e.rdy));
         for (int k = 0; k < 4; k++) begin
            if (k < mon_e.cnt) begin
               chk(mon_e.name, $sformatf("inst%0d", k), 64'(dq_i[k]), 64'({1'b1, enc(mon_e.pc[k])}));
               chk(mon_e.name, $sformatf("pc%0d", k), 64'(dq_p[k]), 64'(mon_e.pc[k]));
            end else begin
               chk(mon_e.name, $sformatf("inst%0d", k), 64'(dq_i[k]), 64'd0);
               chk(mon_e.name, $sformatf("pc%0d", k), 64'(dq_p[k]), 64'd0);
            end
         end
`ifdef IQ_PERF_EN
         if (mon_e.name == "reset") begin
            chk(mon_e.name, "stall_cycles", 64'(stall_cycles), 64'd0);
            chk(mon_e.name, "empty_cycles", 64'(empty_cycles), 64'd0);
         end
`endif
      end
   end

   initial begin
      resetn = 1'b0;
      step(0, 0, 32'h0, 4'h0, 3'd0);
      step(0, 0, 32'h0, 4'h0, 3'd0);
      exp_state("reset", 0, 1, 0, 0, 0, 0);
      step(0, 1, 32'h0100, 4'hF, 3'd4);
      resetn = 1'b1;

      exp_state("grp4",      4,  1, 32'h1000, 32'h1004, 32'h1008, 32'h100C); step(0, 1, 32'h1000, 4'hF,    3'd0);
      exp_state("lead2",     6,  1, 32'h1000, 32'h1004, 32'h1008, 32'h100C); step(0, 1, 32'h2000, 4'b1011, 3'd0);
      exp_state("deq4",      2,  1, 32'h2000, 32'h2004, 0, 0);               step(0, 0, 32'h0,    4'h0,    3'd4);
      exp_state("g3000",     6,  1, 32'h2000, 32'h2004, 32'h3000, 32'h3004); step(0, 1, 32'h3000, 4'hF,    3'd0);
      exp_state("g4000",     10, 1, 32'h2000, 32'h2004, 32'h3000, 32'h3004); step(0, 1, 32'h4000, 4'hF,    3'd0);
      exp_state("enq_deq",   10, 1, 32'h3008, 32'h300C, 32'h4000, 32'h4004); step(0, 1, 32'h5000, 4'hF,    3'd4);
      exp_state("deq_a",     6,  1, 32'h4008, 32'h400C, 32'h5000, 32'h5004); step(0, 0, 32'h0,    4'h0,    3'd4);
      exp_state("wrap",      4,  1, 32'h5000, 32'h5004, 32'h5008, 32'h500C); step(0, 0, 32'h0,    4'h0,    3'd2);
      exp_state("drain",     0,  1, 0, 0, 0, 0);                             step(0, 0, 32'h0,    4'h0,    3'd7);
      exp_state("g6000",     4,  1, 32'h6000, 32'h6004, 32'h6008, 32'h600C); step(0, 1, 32'h6000, 4'hF,    3'd0);
      exp_state("g7000",     8,  1, 32'h6000, 32'h6004, 32'h6008, 32'h600C); step(0, 1, 32'h7000, 4'hF,    3'd0);
      exp_state("g8000",     12, 1, 32'h6000, 32'h6004, 32'h6008, 32'h600C); step(0, 1, 32'h8000, 4'hF,    3'd0);
      exp_state("lead1",     13, 0, 32'h6000, 32'h6004, 32'h6008, 32'h600C); step(0, 1, 32'h9000, 4'b0101, 3'd0);
      exp_state("blocked",   9,  1, 32'h7000, 32'h7004, 32'h7008, 32'h700C); step(0, 1, 32'hA000, 4'hF,    3'd4);
      exp_state("g_b000",    13, 0, 32'h7000, 32'h7004, 32'h7008, 32'h700C); step(0, 1, 32'hB000, 4'hF,    3'd0);
      exp_state("deq1",      12, 1, 32'h7004, 32'h7008, 32'h700C, 32'h8000); step(0, 0, 32'h0,    4'h0,    3'd1);
      exp_state("full",      16, 0, 32'h7004, 32'h7008, 32'h700C, 32'h8000); step(0, 1, 32'hC000, 4'hF,    3'd0);
      exp_state("full_hold", 16, 0, 32'h7004, 32'h7008, 32'h700C, 32'h8000); step(0, 1, 32'hD000, 4'hF,    3'd0);
      exp_state("clamp",     12, 1, 32'h8004, 32'h8008, 32'h800C, 32'h9000); step(0, 0, 32'h0,    4'h0,    3'd6);
      exp_state("deq_b",     8,  1, 32'hB000, 32'hB004, 32'hB008, 32'hB00C); step(0, 0, 32'h0,    4'h0,    3'd4);
      exp_state("pre_flush", 7,  1, 32'hB004, 32'hB008, 32'hB00C, 32'hC000); step(0, 0, 32'h0,    4'h0,    3'd1);
      exp_state("flush",     0,  1, 0, 0, 0, 0);                             step(1, 1, 32'hE000, 4'hF,    3'd2);
      exp_state("g_f000",    2,  1, 32'hF000, 32'hF004, 0, 0);               step(0, 1, 32'hF000, 4'b0011, 3'd0);
      exp_state("deq_over",  0,  1, 0, 0, 0, 0);                             step(0, 0, 32'h0,    4'h0,    3'd4);
      exp_state("empty_deq", 0,  1, 0, 0, 0, 0);                             step(0, 0, 32'h0,    4'h0,    3'd4);
      exp_state("post",      4,  1, 32'h1230, 32'h1234, 32'h1238, 32'h123C); step(0, 1, 32'h1230, 4'hF,    3'd0);

      resetn = 1'b0;
      exp_state("rst_mid",   0,  1, 0, 0, 0, 0);                             step(0, 1, 32'h2220, 4'hF,    3'd1);
      resetn = 1'b1;
      exp_state("post_rst",  4,  1, 32'h3330, 32'h3334, 32'h3338, 32'h333C); step(0, 1, 32'h3330, 4'hF,    3'd0);

      step(0, 0, 32'h0, 4'h0, 3'd0);
      step(0, 0, 32'h0, 4'h0, 3'd0);

      n_cmp++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left unchecked, expected 0", sbq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
